// File: rtl/bz_flit_deserializer.sv
// Reassembles 11-bit router flits (header + 3-flit data groups) into full
// {route, code, payload} words and presents them on a valid/ack channel.
module bz_flit_deserializer #(
  parameter int unsigned NPCroute = 8,
  parameter int unsigned NPCcode  = 7,
  parameter int unsigned NPCdata  = 20
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [10:0]                          fifo_q,
  input  logic                                 fifo_empty,
  output logic                                 fifo_rdreq,
  output logic [NPCroute+NPCcode+NPCdata-1:0]  out_d,
  output logic                                 out_v,
  input  logic                                 out_a,
  output logic                                 proto_err
);

  localparam int unsigned DataW = NPCcode + NPCdata;

  typedef enum logic [2:0] {
    ST_HEAD = 3'd0,
    ST_D1   = 3'd1,
    ST_D2   = 3'd2,
    ST_D3   = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [NPCroute-1:0] route_r;
  logic [DataW-1:0]    data_r;
  logic                tail_r;

  logic pop;
  logic flit_tail;
  logic ld_route;
  logic ld_d1;
  logic ld_d2;
  logic ld_d3;
  logic err_nxt;

  assign flit_tail = fifo_q[10];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_HEAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, pop request and field load enables
  always_comb begin
    state_nxt  = state;
    fifo_rdreq = 1'b0;
    ld_route   = 1'b0;
    ld_d1      = 1'b0;
    ld_d2      = 1'b0;
    ld_d3      = 1'b0;
    err_nxt    = 1'b0;
    // Reset gating keeps the pop low while the block is held in reset
    pop        = !fifo_empty && !reset;
    case (state)
      ST_HEAD: begin
        fifo_rdreq = pop;
        if (pop) begin
          if (flit_tail) begin
            err_nxt = 1'b1;
          end else begin
            ld_route  = 1'b1;
            state_nxt = ST_D1;
          end
        end
      end
      ST_D1: begin
        fifo_rdreq = pop;
        if (pop) begin
          if (flit_tail) begin
            err_nxt   = 1'b1;
            state_nxt = ST_HEAD;
          end else begin
            ld_d1     = 1'b1;
            state_nxt = ST_D2;
          end
        end
      end
      ST_D2: begin
        fifo_rdreq = pop;
        if (pop) begin
          if (flit_tail) begin
            err_nxt   = 1'b1;
            state_nxt = ST_HEAD;
          end else begin
            ld_d2     = 1'b1;
            state_nxt = ST_D3;
          end
        end
      end
      ST_D3: begin
        fifo_rdreq = pop;
        if (pop) begin
          ld_d3     = 1'b1;
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        // A non-tail group keeps route_r for the next data group
        if (out_a) begin
          state_nxt = tail_r ? ST_HEAD : ST_D1;
        end
      end
      default: begin
        state_nxt = ST_HEAD;
      end
    endcase
  end

  // Field capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      route_r <= '0;
      data_r  <= '0;
      tail_r  <= 1'b0;
    end else begin
      if (ld_route) begin
        route_r <= fifo_q[NPCroute-1:0];
      end
      if (ld_d1) begin
        data_r[26:20] <= fifo_q[6:0];
      end
      if (ld_d2) begin
        data_r[19:10] <= fifo_q[9:0];
      end
      if (ld_d3) begin
        data_r[9:0] <= fifo_q[9:0];
        tail_r      <= flit_tail;
      end
    end
  end

  // One-cycle framing error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else begin
      proto_err <= err_nxt;
    end
  end

  assign out_v = (state == ST_OUT);
  assign out_d = {route_r, data_r};

endmodule

// File: tb/tb_bz_flit_deserializer.sv
// Self-checking bench: FIFO model feeds flit streams, a stream-level parser
// predicts the words and framing errors the deserializer must produce.
module tb_bz_flit_deserializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [34:0] out_d;
  logic        out_v;
  logic        out_a;
  logic        proto_err;

  bz_flit_deserializer #(.NPCroute(8), .NPCcode(7), .NPCdata(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq),
    .out_d      (out_d),
    .out_v      (out_v),
    .out_a      (out_a),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [10:0] fq[$];
  logic [10:0] stim[$];
  logic [34:0] exp_w[$];
  logic [34:0] got[$];
  int          exp_errs;

  int   cyc = 0;
  int   pops, errs_seen, first_pop, vrise, acc_cyc, pop_after, vcnt;
  bit   starve = 0;
  bit   gap = 0;
  int   ack_mode = 0;
  bit   prev_hold = 0;
  logic [34:0] prev_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    fifo_empty = (fq.size() == 0) || gap;
    fifo_q     = (fq.size() != 0) ? fq[0] : 11'h000;
  endtask

  // Stream-level reference: header, then 3-flit groups; a tail flit anywhere but
  // the 3rd group position is a framing error that restarts at a header.
  task automatic model();
    int          i;
    bit          need_hdr;
    logic [7:0]  route;
    logic [10:0] g[3];
    bit          broke;
    int          k;
    exp_w.delete();
    exp_errs = 0;
    i = 0;
    need_hdr = 1;
    route = '0;
    while (i < stim.size()) begin
      if (need_hdr) begin
        if (stim[i][10]) exp_errs++;
        else begin
          route = stim[i][7:0];
          need_hdr = 0;
        end
        i++;
      end else begin
        broke = 0;
        k = 0;
        while (k < 3 && i < stim.size() && !broke) begin
          g[k] = stim[i];
          i++;
          if (k < 2 && g[k][10]) begin
            exp_errs++;
            need_hdr = 1;
            broke = 1;
          end
          k++;
        end
        if (!broke && k == 3) begin
          exp_w.push_back({route, g[0][6:0], g[1][9:0], g[2][9:0]});
          need_hdr = g[2][10];
        end
      end
    end
  endtask

  task automatic tick();
    logic pop_now;
    @(negedge clk);
    cyc++;
    chk("rdreq_while_empty", 64'(fifo_rdreq & fifo_empty), 64'd0);
    chk("rdreq_in_out", 64'(fifo_rdreq & out_v), 64'd0);
    if (prev_hold) begin
      chk("hold_out_v", 64'(out_v), 64'd1);
      chk("hold_out_d", 64'(out_d), 64'(prev_d));
    end
    prev_hold = out_v && !out_a;
    prev_d    = out_d;
    pop_now   = fifo_rdreq;
    if (out_v) begin
      if (vrise < 0) vrise = cyc;
      vcnt++;
    end else begin
      vcnt = 0;
    end
    if (out_v && out_a) begin
      got.push_back(out_d);
      if (acc_cyc < 0) acc_cyc = cyc;
    end
    if (proto_err) errs_seen++;
    if (pop_now) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      if (acc_cyc >= 0 && pop_after < 0) pop_after = cyc;
    end
    @(posedge clk);
    #1;
    if (pop_now && fq.size() != 0) void'(fq.pop_front());
    if (starve) gap = !gap;
    case (ack_mode)
      0:       out_a = 1'b1;
      1:       out_a = (vcnt >= 7);
      default: out_a = 1'($urandom_range(0, 1));
    endcase
    drive();
  endtask

  task automatic start_scn();
    got.delete();
    errs_seen = 0;
    pops      = 0;
    first_pop = -1;
    vrise     = -1;
    acc_cyc   = -1;
    pop_after = -1;
    vcnt      = 0;
    gap       = 0;
    model();
    foreach (stim[i]) fq.push_back(stim[i]);
    drive();
  endtask

  task automatic finish_scn(input string name);
    chk({name, "_words"}, 64'(got.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      chk({name, "_word"}, 64'(got[i]), 64'(exp_w[i]));
    chk({name, "_errs"}, 64'(errs_seen), 64'(exp_errs));
    chk({name, "_pops"}, 64'(pops), 64'(stim.size()));
    chk({name, "_drained"}, 64'(fq.size()), 64'd0);
  endtask

  task automatic run_scn(input string name, input int cycles);
    start_scn();
    repeat (cycles) tick();
    finish_scn(name);
  endtask

  task automatic add_pkt(input logic [7:0] route, input int groups, input bit bad_d1);
    stim.push_back({1'b0, {2{route[7]}}, route});
    for (int g = 0; g < groups; g++) begin
      stim.push_back(bad_d1 && g == 0 ? {1'b1, 10'($urandom)} : {1'b0, 10'($urandom)});
      stim.push_back({1'b0, 10'($urandom)});
      stim.push_back({(g == groups - 1), 10'($urandom)});
    end
  endtask

  initial begin
    reset = 1'b1;
    fifo_empty = 1'b1;
    fifo_q = '0;
    out_a = 1'b0;
    #3;
    chk("rst_out_v", 64'(out_v), 64'd0);
    chk("rst_out_d", 64'(out_d), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    fifo_empty = 1'b0;
    #1;
    chk("rst_rdreq", 64'(fifo_rdreq), 64'd0);
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_a = 1'b1;

    // Single packet: word value and latency from first pop
    stim = '{11'h005, 11'h023, 11'h155, 11'h4AA};
    run_scn("single", 12);
    chk("single_const", 64'(got.size() != 0 ? got[0] : 35'h0),
        64'({8'h05, 7'h23, 10'h155, 10'h0AA}));
    chk("single_latency", 64'(vrise - first_pop), 64'd4);

    // Header reuse across three groups
    stim = '{11'h011, 11'h001, 11'h002, 11'h003, 11'h004, 11'h005, 11'h006,
             11'h007, 11'h008, 11'h409};
    run_scn("reuse", 20);
    chk("reuse_count", 64'(got.size()), 64'd3);

    // Output backpressure with a full FIFO
    stim.delete();
    add_pkt(8'h3C, 1, 0);
    add_pkt(8'hC5, 1, 0);
    ack_mode = 1;
    run_scn("bp", 40);
    chk("bp_next_pop", 64'(pop_after - acc_cyc), 64'd1);
    ack_mode = 0;
    out_a = 1'b1;

    // FIFO starvation gives the same word
    stim = '{11'h005, 11'h023, 11'h155, 11'h4AA};
    starve = 1;
    run_scn("starve", 20);
    starve = 0;
    chk("starve_const", 64'(got.size() != 0 ? got[0] : 35'h0),
        64'({8'h05, 7'h23, 10'h155, 10'h0AA}));

    // Framing errors: bad Data 1, then two tailed headers back to back
    stim = '{11'h002, 11'h401, 11'h400, 11'h400, 11'h07F, 11'h07F, 11'h3FF, 11'h4AB};
    run_scn("frame", 24);
    chk("frame_errs_abs", 64'(errs_seen), 64'd3);

    // Async reset after the Data 2 pop
    stim.delete();
    add_pkt(8'h66, 1, 0);
    start_scn();
    for (int i = 0; i < 40 && pops < 3; i++) tick();
    chk("rst_mid_pops", 64'(pops), 64'd3);
    reset = 1'b1;
    #1;
    chk("rst_mid_out_v", 64'(out_v), 64'd0);
    chk("rst_mid_out_d", 64'(out_d), 64'd0);
    chk("rst_mid_rdreq", 64'(fifo_rdreq), 64'd0);
    chk("rst_mid_proto_err", 64'(proto_err), 64'd0);
    fq.delete();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    prev_hold = 0;
    stim.delete();
    add_pkt(8'h9A, 2, 0);
    run_scn("after_rst", 24);

    // Randomized stream with gaps, random ack and injected framing errors
    for (int r = 0; r < 3; r++) begin
      stim.delete();
      for (int p = 0; p < 10; p++)
        add_pkt(8'($urandom), $urandom_range(1, 3), (p % 4) == 3);
      starve = (r == 1);
      ack_mode = (r == 0) ? 0 : 2;
      run_scn("random", stim.size() * 8 + 60);
    end
    starve = 0;
    ack_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
